// File: rtl/rng_ctrl_pkg.sv
// Shared definitions for the simplerng iomem controller:
// register map, status/ctrl bits, FSM encoding, error word.
package rng_ctrl_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_SEED = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int ST_BUSY   = 0;
  localparam int ST_AVAIL  = 1;
  localparam int ST_ERR    = 2;
  localparam int ST_LVL_LO = 4;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_FETCH,
    S_RESP
  } rng_state_e;

  function automatic logic [31:0] merge_be(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8]
                          : old_w[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rng_iomem_ctrl_if.sv
// picosoc iomem slave bus bundle for the RNG controller.
// The CPU side is master, the controller is slave.
interface rng_iomem_ctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb,
    output iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb,
    input  iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/rng_ctrl_fifo.sv
// Small synchronous prefetch FIFO (power-of-2 depth, 2..16)
// with push/pop/flush and an occupancy level.
module rng_ctrl_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [4:0]  level,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = level == 5'(DEPTH);
  assign empty   = level == 5'd0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      level <= level + 5'(do_push) - 5'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/rng_iomem_ctrl.sv
// simplerng sequencer on the picosoc iomem bus.
// Optional background prefetch FIFO: RNG_CTRL_PREFETCH_EN.
module rng_iomem_ctrl
  import rng_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h04,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        resetn,
  rng_iomem_ctrl_if.slave bus,
  output logic        rng_enable,
  output logic        rng_dat_we,
  output logic        rng_dat_re,
  output logic [31:0] rng_dat_di,
  input  logic [31:0] rng_dat_do,
  input  logic        rng_dat_wait
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  rng_state_e  state;
  logic        en_q;
  logic        err_q;
  logic        bg_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] seed_q;
  logic [31:0] data_q;
  logic [7:0]  tcnt;

  logic        hit;
  logic        acc;
  logic        wr;
  logic        en_new;
  logic [1:0]  reg_sel;
  logic [31:0] seed_m;
  logic [7:0]  tnxt;
  logic        tmo_hit;
  logic [31:0] status;
  logic        empty;
  logic        bg_go;
  logic [31:0] fifo_dout;
  logic        unused_addr;

  assign hit     = bus.iomem_valid
                && bus.iomem_addr[31:24] == BASE_ADDR;
  assign acc     = hit && !ready_q && state == S_IDLE;
  assign wr      = |bus.iomem_wstrb;
  assign reg_sel = bus.iomem_addr[3:2];
  assign en_new  = bus.iomem_wstrb[0]
                 ? bus.iomem_wdata[CTRL_EN] : en_q;
  assign seed_m  = merge_be(seed_q, bus.iomem_wdata,
                            bus.iomem_wstrb);
  assign tnxt    = tcnt + 8'd1;
  assign tmo_hit = tnxt == TMO;

  assign unused_addr = ^{bus.iomem_addr[23:4],
                         bus.iomem_addr[1:0]};

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign rng_enable      = en_q;

`ifdef RNG_CTRL_PREFETCH_EN
  logic       full;
  logic [4:0] level;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;

  assign fifo_push  = state == S_FETCH && bg_q
                   && !rng_dat_wait;
  assign fifo_pop   = acc && !wr && en_q && !empty
                   && reg_sel == REG_DATA;
  assign fifo_flush = acc && wr
                   && (reg_sel == REG_SEED
                   || (reg_sel == REG_CTRL && en_q && !en_new));
  // Any bus request on our page outranks a new fill.
  assign bg_go      = en_q && !full && !hit;

  rng_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (rng_dat_do),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );
`else
  localparam int unused_depth = FIFO_DEPTH;
  assign empty     = 1'b1;
  assign bg_go     = 1'b0;
  assign fifo_dout = '0;
`endif

  always_comb begin
    status          = '0;
    status[ST_BUSY] = state != S_IDLE;
    status[ST_ERR]  = err_q;
`ifdef RNG_CTRL_PREFETCH_EN
    status[ST_AVAIL]       = !empty;
    status[ST_LVL_LO +: 5] = level;
`else
    status[ST_AVAIL] = state == S_RESP;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      bg_q       <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      seed_q     <= '0;
      data_q     <= '0;
      tcnt       <= '0;
      rng_dat_we <= 1'b0;
      rng_dat_re <= 1'b0;
      rng_dat_di <= '0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (acc) begin
            ready_q <= 1'b1;
            unique case (reg_sel)
              REG_CTRL: begin
                if (wr) en_q <= en_new;
                else rdata_q <= {31'b0, en_q};
              end
              REG_SEED: begin
                if (wr) begin
                  seed_q <= seed_m;
                  if (en_q) begin
                    ready_q    <= 1'b0;
                    bg_q       <= 1'b0;
                    rng_dat_we <= 1'b1;
                    rng_dat_di <= seed_m;
                    state      <= S_SEED;
                  end
                end
              end
              REG_DATA: begin
                if (!wr && en_q) begin
                  if (!empty) begin
                    rdata_q <= fifo_dout;
                  end else begin
                    ready_q    <= 1'b0;
                    bg_q       <= 1'b0;
                    rng_dat_re <= 1'b1;
                    state      <= S_FETCH;
                  end
                end
              end
              REG_STAT: begin
                if (!wr) rdata_q <= status;
                else if (bus.iomem_wstrb[0]
                      && bus.iomem_wdata[ST_ERR])
                  err_q <= 1'b0;
              end
            endcase
          end else if (bg_go) begin
            bg_q       <= 1'b1;
            rng_dat_re <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_SEED, S_FETCH: begin
          if (!rng_dat_wait || tmo_hit) begin
            rng_dat_we <= 1'b0;
            rng_dat_re <= 1'b0;
            tcnt       <= '0;
            state      <= bg_q ? S_IDLE : S_RESP;
            if (state == S_SEED) data_q <= '0;
            else if (!rng_dat_wait) data_q <= rng_dat_do;
            else data_q <= ERR_WORD;
            if (rng_dat_wait) err_q <= 1'b1;
          end else begin
            tcnt <= tnxt;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          rdata_q <= data_q;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_iomem_ctrl.sv
// Directed bench for rng_iomem_ctrl: vector table plus
// timeout, reset and (with RNG_CTRL_PREFETCH_EN) prefetch sequences.
module tb_rng_iomem_ctrl;
  import rng_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rng_enable;
  logic        rng_dat_we;
  logic        rng_dat_re;
  logic [31:0] rng_dat_di;
  logic [31:0] rng_dat_do;
  logic        rng_dat_wait;

  always #5 clk = ~clk;

  rng_iomem_ctrl_if bif ();

  rng_iomem_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bif),
    .rng_enable  (rng_enable),
    .rng_dat_we  (rng_dat_we),
    .rng_dat_re  (rng_dat_re),
    .rng_dat_di  (rng_dat_di),
    .rng_dat_do  (rng_dat_do),
    .rng_dat_wait(rng_dat_wait)
  );

  // simplerng model: wait held for wait_n cycles per request
  int          wait_n = 0;
  logic        stuck = 1'b0;
  int          age = 0;
  logic        pf_mode = 1'b0;
  logic [31:0] pf_idx = '0;
  logic [31:0] do_fix = '0;

  always @(posedge clk) begin
    if (rng_dat_re || rng_dat_we) age <= age + 1;
    else age <= 0;
    if (rng_dat_re && !rng_dat_wait) pf_idx <= pf_idx + 1;
  end

  assign rng_dat_wait = stuck
    || ((rng_dat_re || rng_dat_we) && age < wait_n);
  assign rng_dat_do = pf_mode ? 32'hA000_0000 + pf_idx
                              : do_fix;

  int          re_cnt = 0;
  int          we_cnt = 0;
  logic [31:0] di_seen = '0;

  always @(negedge clk) begin
    if (rng_dat_re) re_cnt++;
    if (rng_dat_we) begin
      we_cnt++;
      di_seen = rng_dat_di;
    end
  end

  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [3:0] off,
                     input logic [3:0] be,
                     input logic [31:0] wd,
                     input int budget,
                     output logic [31:0] rd,
                     output int lat);
    int   dead;
    logic got;
    dead = bif.iomem_ready ? 1 : 0;
    re_cnt = 0;
    we_cnt = 0;
    got = 1'b0;
    lat = 0;
    rd = '0;
    bif.iomem_addr  = {8'h04, 20'h0, off};
    bif.iomem_wstrb = be;
    bif.iomem_wdata = wd;
    bif.iomem_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bif.iomem_ready) begin
        rd = bif.iomem_rdata;
        got = 1'b1;
        break;
      end
    end
    bif.iomem_valid = 1'b0;
    bif.iomem_wstrb = '0;
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL bus_timeout off=%h: no ready in %0d cycles",
               off, budget);
    end
    lat = lat - dead;
  endtask

  typedef struct {
    logic [3:0]  off;
    logic [3:0]  be;
    logic [31:0] wd;
    int          wn;
    logic [31:0] dov;
    logic [31:0] rd;
    int          lat;
    int          req;
    logic [31:0] di;
  } vec_t;

  vec_t        vt [15];
  logic [31:0] rd;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bif.iomem_valid = 1'b0;
    bif.iomem_wstrb = '0;
    bif.iomem_addr  = '0;
    bif.iomem_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {28'b0, rng_enable, rng_dat_we, rng_dat_re,
         bif.iomem_ready}, '0);
    chk("reset_rdata", bif.iomem_rdata, '0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

`ifndef RNG_CTRL_PREFETCH_EN
    //          off   be     wd            wn dov            rd            lat req di
    vt[0]  = '{4'h0, 4'h0, 32'h0,        0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[1]  = '{4'hC, 4'h0, 32'h0,        0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[2]  = '{4'h8, 4'h0, 32'h0,        0, 32'h1111_1111, 32'h0,         1, 0, 32'h0};
    vt[3]  = '{4'h4, 4'hF, 32'hDEADDEAD, 0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[4]  = '{4'h0, 4'h2, 32'h1,        0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[5]  = '{4'h0, 4'h0, 32'h0,        0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[6]  = '{4'h0, 4'h1, 32'h1,        0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[7]  = '{4'h0, 4'h0, 32'h0,        0, 32'h0,         32'h1,         1, 0, 32'h0};
    vt[8]  = '{4'h4, 4'hF, 32'h12345678, 2, 32'h0,         32'h0,         5, 3, 32'h12345678};
    vt[9]  = '{4'h4, 4'h1, 32'hFFFFFFAB, 0, 32'h0,         32'h0,         3, 1, 32'h123456AB};
    vt[10] = '{4'h8, 4'h0, 32'h0,        5, 32'hCAFE_0001, 32'hCAFE_0001, 8, 6, 32'h0};
    vt[11] = '{4'h8, 4'h0, 32'h0,        0, 32'hCAFE_0002, 32'hCAFE_0002, 3, 1, 32'h0};
    vt[12] = '{4'h8, 4'hF, 32'h5,        0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[13] = '{4'hC, 4'h0, 32'h0,        0, 32'h0,         32'h0,         1, 0, 32'h0};
    vt[14] = '{4'h4, 4'h0, 32'h0,        0, 32'h0,         32'h0,         1, 0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      wait_n = vt[i].wn;
      do_fix = vt[i].dov;
      bus(vt[i].off, vt[i].be, vt[i].wd, 50, rd, lat);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_req", i),
          32'(re_cnt + we_cnt), 32'(vt[i].req));
      if (vt[i].req > 0 && vt[i].off == 4'h4)
        chk($sformatf("v%0d_di", i), di_seen, vt[i].di);
    end

    // wait stuck high: abort after 255 wait cycles
    wait_n = 0;
    stuck = 1'b1;
    bus(4'h8, 4'h0, 32'h0, 400, rd, lat);
    stuck = 1'b0;
    chk("tmo_rdata", rd, ERR_WORD);
    chk("tmo_lat", 32'(lat), 32'd257);
    chk("tmo_re_cycles", 32'(re_cnt), 32'd255);
    bus(4'hC, 4'h0, 32'h0, 20, rd, lat);
    chk("tmo_err_set", rd, 32'h4);
    bus(4'hC, 4'hF, 32'h4, 20, rd, lat);
    chk("err_clr_lat", 32'(lat), 32'd1);
    bus(4'hC, 4'h0, 32'h0, 20, rd, lat);
    chk("err_cleared", rd, 32'h0);
`else
    pf_mode = 1'b1;
    bus(4'h0, 4'h1, 32'h1, 20, rd, lat);
    chk("pf_en_lat", 32'(lat), 32'd1);
    repeat (50) @(posedge clk);
    #1;
    bus(4'hC, 4'h0, 32'h0, 20, rd, lat);
    chk("pf_full_status", rd, 32'h42);
    for (int k = 0; k < 4; k++) begin
      bus(4'h8, 4'h0, 32'h0, 20, rd, lat);
      chk($sformatf("pf_pop%0d_data", k), rd,
          32'hA000_0000 + 32'(k));
      chk($sformatf("pf_pop%0d_lat", k), 32'(lat), 32'd1);
      chk($sformatf("pf_pop%0d_req", k), 32'(re_cnt), 32'd0);
    end
    repeat (50) @(posedge clk);
    #1;
    bus(4'hC, 4'h0, 32'h0, 20, rd, lat);
    chk("pf_refill_status", rd, 32'h42);
    bus(4'h4, 4'hF, 32'h1234_5678, 20, rd, lat);
    chk("pf_seed_lat", 32'(lat), 32'd3);
    chk("pf_seed_di", di_seen, 32'h1234_5678);
    bus(4'hC, 4'h0, 32'h0, 20, rd, lat);
    chk("pf_flush_status", rd, 32'h0);
    pf_mode = 1'b0;
`endif

    // async reset in the middle of a FETCH
    stuck = 1'b1;
    bif.iomem_addr  = {8'h04, 24'h8};
    bif.iomem_wstrb = 4'h0;
    bif.iomem_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rng_dat_re) break;
    end
    chk("rst_pre_re", {31'b0, rng_dat_re}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_outs_now",
        {28'b0, rng_enable, rng_dat_we, rng_dat_re,
         bif.iomem_ready}, '0);
    bif.iomem_valid = 1'b0;
    stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_ack", {31'b0, bif.iomem_ready}, '0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    bus(4'h0, 4'h0, 32'h0, 20, rd, lat);
    chk("rst_ctrl", rd, 32'h0);
    bus(4'hC, 4'h0, 32'h0, 20, rd, lat);
    chk("rst_status", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
